icache: RTL

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller's ICache port. Read hits are served combinationally in the request cycle. A miss raises a single 4-byte fetch request to the memory controller, holds it until the word is committed, writes the line, and forwards the word to fetch in the commit cycle. A branch-mispredict `roll` cancels an outstanding fill.

---
 rtl/icache_if.sv | 22 ++
 rtl/icache.sv | 101 ++++++++++
 2 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache; the master modport is the fetch stage plus controller.
interface icache_if;
  logic        IF_flag;
  logic [31:0] IF_pc;
  logic        IF_hit;
  logic [31:0] IF_inst;
  logic        MC_flag;
  logic [31:0] MC_addr;
  logic        MC_commit;
  logic [31:0] MC_data;

  modport slave (
    input  IF_flag, IF_pc, MC_commit, MC_data,
    output IF_hit, IF_inst, MC_flag, MC_addr
  );

  modport master (
    output IF_flag, IF_pc, MC_commit, MC_data,
    input  IF_hit, IF_inst, MC_flag, MC_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// miss, commit-cycle forwarding and roll cancellation.
module icache #(
  parameter int unsigned ADDR_BITS  = 18,
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     roll,
  icache_if.slave  bus
);

  localparam int unsigned Lines   = 2 ** INDEX_BITS;
  localparam int unsigned TagBits = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                  state_q, state_d;
  logic [29:0]             fill_line_q, fill_line_d;
  logic [INDEX_BITS-1:0]   fill_idx_q, fill_idx_d;

  logic [Lines-1:0]        valid_q;
  logic [TagBits-1:0]      tag_mem  [Lines];
  logic [31:0]             data_mem [Lines];

  logic [INDEX_BITS-1:0]   idx;
  logic [TagBits-1:0]      pc_tag;
  logic                    lookup_hit;
  logic                    commit;
  logic                    fwd;
  logic                    unused_pc;

  assign idx        = bus.IF_pc[INDEX_BITS+1:2];
  assign pc_tag     = bus.IF_pc[ADDR_BITS-1:INDEX_BITS+2];
  assign lookup_hit = bus.IF_flag & valid_q[idx] & (tag_mem[idx] == pc_tag);
  assign unused_pc  = ^bus.IF_pc[1:0];

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    fill_idx_d  = fill_idx_q;
    commit      = 1'b0;
    if (rdy) begin
      unique case (state_q)
        StIdle: begin
          if (bus.IF_flag && !lookup_hit && !roll) begin
            state_d     = StFill;
            fill_line_d = bus.IF_pc[31:2];
            fill_idx_d  = idx;
          end
        end
        StFill: begin
          // A commit wins over roll: the fetched word is still correct for fill_line_q.
          if (bus.MC_commit) begin
            commit  = 1'b1;
            state_d = StIdle;
          end else if (roll) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    fwd         = commit & bus.IF_flag & (bus.IF_pc[31:2] == fill_line_q) & ~roll;
    bus.IF_hit  = rdy & (fwd | lookup_hit);
    bus.IF_inst = fwd ? bus.MC_data : data_mem[idx];
    // Commit/roll only act while rdy is high, so a frozen request stays asserted.
    bus.MC_flag = (state_q == StFill) & ~(rdy & (bus.MC_commit | roll));
    bus.MC_addr = (state_q == StFill) ? {fill_line_q, 2'b00} : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      fill_line_q <= '0;
      fill_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      fill_idx_q  <= fill_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (commit) begin
      valid_q[fill_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      tag_mem[fill_idx_q]  <= fill_line_q[ADDR_BITS-3:INDEX_BITS];
      data_mem[fill_idx_q] <= bus.MC_data;
    end
  end

endmodule
